// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: sync + glitch filter + frame FSM + E0/F0 prefix decoder.
// Latency: raw stop-bit falling edge to key_valid/frame_err = FILTER_LEN+4 clk cycles.
// Backpressure: none; events are one-cycle pulses. Macro PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN = 4,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] WDOG_LAST = TIMEOUT - 16'd1;

  // Input conditioning state
  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [3:0] flt_cnt_q;
  logic       clk_f_q, clk_f_prev_q, fall_q;

  // Frame and decoder state
  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic [15:0] wdog_q, wdog_d;
  logic        ext_pend_q, ext_pend_d;
  logic        brk_pend_q, brk_pend_d;
  logic [7:0]  keycode_q, keycode_d;
  logic        make_q, make_d;
  logic        kext_q, kext_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        stop_ok;
  logic        byte_done;

  // Synchronize both lines, debounce ps2_clk, and register its falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      flt_cnt_q    <= 4'd0;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      fall_q       <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      clk_f_prev_q <= clk_f_q;
      fall_q       <= clk_f_prev_q & ~clk_f_q;
      if (clk_s2_q == clk_f_q) begin
        flt_cnt_q <= 4'd0;
      end else if (flt_cnt_q == FLT_LAST) begin
        flt_cnt_q <= 4'd0;
        clk_f_q   <= clk_s2_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + 4'd1;
      end
    end
  end

  // Frame/decoder state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      wdog_q     <= 16'd0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      keycode_q  <= 8'd0;
      make_q     <= 1'b0;
      kext_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      wdog_q     <= wdog_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      keycode_q  <= keycode_d;
      make_q     <= make_d;
      kext_q     <= kext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Stop-bit acceptance; parity only matters when checking is compiled in.
`ifdef PS2_PARITY_CHECK_EN
  assign stop_ok = dat_s2_q & (^{shreg_q, par_q});
`else
  assign stop_ok = dat_s2_q;
`endif

  // Next-state: frame FSM, watchdog, prefix decoder and output events.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    wdog_d     = wdog_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    keycode_d  = keycode_q;
    make_d     = make_q;
    kext_d     = kext_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    byte_done  = 1'b0;

    // wdog_q holds the number of cycles elapsed since the last fall.
    if (fall_q) begin
      wdog_d = 16'd1;
    end else if (state_q == ST_IDLE) begin
      wdog_d = 16'd0;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_q) begin
          if (!dat_s2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (fall_q) begin
          shreg_d  = {dat_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall_q) begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_q) begin
          state_d = ST_IDLE;
          if (stop_ok) begin
            byte_done = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fall arriving on the deciding cycle keeps the frame alive.
    if (state_q != ST_IDLE && !fall_q && wdog_q == WDOG_LAST) begin
      state_d = ST_IDLE;
      wdog_d  = 16'd0;
      err_d   = 1'b1;
    end

    if (byte_done) begin
      if (shreg_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shreg_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        keycode_d  = shreg_q;
        kext_d     = ext_pend_q;
        make_d     = ~brk_pend_q;
        valid_d    = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end

    if (err_d) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  assign keycode   = keycode_q;
  assign key_make  = make_q;
  assign key_ext   = kext_q;
  assign key_valid = valid_q;
  assign frame_err = err_q;

endmodule
